// File: rtl/ir_key_sched_if.sv
// Bus between the IR key scheduler and its neighbours: decoded receiver
// inputs, the event queue consumer port and the scheduler's debug state.
interface ir_key_sched_if;
    logic        en;
    logic [15:0] ir_code;
    logic        ir_code_ack;
    logic [7:0]  ir_code_cnt;
    logic [17:0] evt_data;
    logic        evt_valid;
    logic        evt_ready;
    logic [2:0]  evt_level;
    logic        ovf;
    logic        ovf_clr;
    logic [1:0]  state;

    // Handshake: evt_valid means evt_data holds the oldest queued event; it is
    // consumed on a rising edge where evt_valid and evt_ready are both high.
    // evt_valid never depends on evt_ready, and evt_ready with evt_valid low does nothing.
    modport master (
        output en, ir_code, ir_code_ack, ir_code_cnt, evt_ready, ovf_clr,
        input  evt_data, evt_valid, evt_level, ovf, state
    );

    modport slave (
        input  en, ir_code, ir_code_ack, ir_code_cnt, evt_ready, ovf_clr,
        output evt_data, evt_valid, evt_level, ovf, state
    );
endinterface

// File: rtl/ir_key_sched.sv
// Turns decoded IR receiver frames into PRESS/REPEAT/RELEASE events in a 4-deep queue.
// REPEAT generation is built only when the macro IR_KEY_REPEAT_EN is defined.
module ir_key_sched #(
    parameter int RPT_DELAY = 4,
    parameter int RPT_DIV   = 2
) (
    input logic          clk27,
    input logic          reset_n,
    ir_key_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        SWITCH = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cur_code;
    logic [15:0] cur_nxt;
    logic [15:0] new_code;
    logic        new_load;
    logic        push_req;
    logic [17:0] push_data;
    logic        clr_rpt;
    logic        rpt_slot;
    logic        rpt_fire;
    logic        push;
    logic [17:0] push_evt;

    // Inputs are used as sampled at the clock edge; no extra synchronizer stages.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_code;
        new_load  = 1'b0;
        push_req  = 1'b0;
        push_data = '0;
        clr_rpt   = 1'b0;
        rpt_slot  = 1'b0;
        if (!bus.en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ir_code_ack && (bus.ir_code != 16'd0)) begin
                        push_req  = 1'b1;
                        push_data = {EVT_PRESS, bus.ir_code};
                        cur_nxt   = bus.ir_code;
                        clr_rpt   = 1'b1;
                        state_nxt = HELD;
                    end
                end
                HELD: begin
                    if (bus.ir_code == 16'd0) begin
                        push_req  = 1'b1;
                        push_data = {EVT_RELEASE, cur_code};
                        state_nxt = DRAIN;
                    end else if (bus.ir_code_ack) begin
                        if (bus.ir_code == cur_code) begin
                            clr_rpt = 1'b1;
                        end else begin
                            push_req  = 1'b1;
                            push_data = {EVT_RELEASE, cur_code};
                            new_load  = 1'b1;
                            state_nxt = SWITCH;
                        end
                    end else begin
                        rpt_slot = 1'b1;
                    end
                end
                SWITCH: begin
                    push_req  = 1'b1;
                    push_data = {EVT_PRESS, new_code};
                    cur_nxt   = new_code;
                    clr_rpt   = 1'b1;
                    state_nxt = HELD;
                end
                DRAIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_code <= '0;
            new_code <= '0;
        end else begin
            state    <= state_nxt;
            cur_code <= cur_nxt;
            if (new_load) begin
                new_code <= bus.ir_code;
            end
        end
    end

    assign bus.state = state;

`ifdef IR_KEY_REPEAT_EN
    localparam logic [7:0] DELAY_TH   = 8'(RPT_DELAY);
    localparam logic [3:0] DIV_RELOAD = 4'(RPT_DIV - 1);

    logic [7:0] rpt_seen;
    logic [3:0] div_cnt;
    logic [7:0] cnt_prev;
    logic       rpt_frame;
    logic       rpt_armed;

    // The >=2 floor keeps a receiver counter wrap (255->0->1) from counting as a frame.
    assign rpt_frame = rpt_slot && (bus.ir_code_cnt != cnt_prev) && (bus.ir_code_cnt >= 8'd2);
    assign rpt_armed = rpt_seen >= DELAY_TH;
    assign rpt_fire  = rpt_frame && rpt_armed && (div_cnt == 4'd0);

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            rpt_seen <= '0;
            div_cnt  <= '0;
            cnt_prev <= '0;
        end else begin
            cnt_prev <= bus.ir_code_cnt;
            if (clr_rpt) begin
                rpt_seen <= '0;
                div_cnt  <= '0;
            end else if (rpt_frame) begin
                if (rpt_seen != 8'hFF) begin
                    rpt_seen <= rpt_seen + 8'd1;
                end
                if (rpt_armed) begin
                    div_cnt <= (div_cnt == 4'd0) ? DIV_RELOAD : div_cnt - 4'd1;
                end
            end
        end
    end
`else
    logic unused_sigs;
    assign unused_sigs = ^{clr_rpt, rpt_slot, bus.ir_code_cnt, RPT_DELAY[0], RPT_DIV[0]};
    assign rpt_fire    = 1'b0;
`endif

    // Repeat frames only occur in HELD with no ack, so rpt_fire never collides with push_req.
    assign push     = push_req | rpt_fire;
    assign push_evt = rpt_fire ? {EVT_REPEAT, cur_code} : push_data;

    logic [17:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  level;
    logic        ovf;
    logic        pop;
    logic        full;
    logic        push_ok;
    logic        drop;

    assign pop     = (level != 3'd0) && bus.evt_ready;
    assign full    = (level == 3'd4);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk27) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_evt;
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign bus.evt_valid = (level != 3'd0);
    assign bus.evt_data  = (level != 3'd0) ? mem[rd_ptr] : '0;
    assign bus.evt_level = level;
    assign bus.ovf       = ovf;

endmodule

// File: tb/tb_ir_key_sched.sv
// Directed scoreboard bench for ir_key_sched (RPT_DELAY=4, RPT_DIV=2); REPEAT
// expectations follow whether IR_KEY_REPEAT_EN is defined for the build.
module tb_ir_key_sched;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HELD   = 2'd1;
    localparam logic [1:0] S_SWITCH = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;
    localparam logic [1:0] T_PRESS  = 2'b01;
    localparam logic [1:0] T_REPEAT = 2'b10;
    localparam logic [1:0] T_REL    = 2'b11;

    logic clk;
    logic rst_n;
    bit   rpt_on;
    int   errors = 0;
    int   checks = 0;
    logic [17:0] exp_q[$];

    ir_key_sched_if bus();

    ir_key_sched #(.RPT_DELAY(4), .RPT_DIV(2)) dut (
        .clk27   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic [1:0] t, input logic [15:0] code);
        exp_q.push_back({t, code});
    endtask

    task automatic ack_code(input logic [15:0] code, input logic [7:0] cnt);
        bus.ir_code     = code;
        bus.ir_code_cnt = cnt;
        bus.ir_code_ack = 1'b1;
        cyc();
        bus.ir_code_ack = 1'b0;
        cyc();
    endtask

    task automatic frame(input logic [7:0] cnt);
        bus.ir_code_cnt = cnt;
        cyc();
    endtask

    task automatic release_key();
        bus.ir_code     = 16'd0;
        bus.ir_code_cnt = 8'd0;
        cyc();
        cyc();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            cyc();
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: a pop happens on the next rising edge whenever valid and ready are both high.
    initial begin
        logic [17:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && bus.evt_valid && bus.evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got=%0h expected=none", bus.evt_data);
                end else begin
                    exp = exp_q.pop_front();
                    check("evt_data", bus.evt_data, exp);
                end
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
`ifdef IR_KEY_REPEAT_EN
        rpt_on = 1'b1;
`else
        rpt_on = 1'b0;
`endif
        rst_n           = 1'b0;
        bus.en          = 1'b1;
        bus.ir_code     = 16'd0;
        bus.ir_code_ack = 1'b0;
        bus.ir_code_cnt = 8'd0;
        bus.evt_ready   = 1'b1;
        bus.ovf_clr     = 1'b0;
        cyc();
        cyc();
        check("rst_state", bus.state, S_IDLE);
        check("rst_valid", bus.evt_valid, 0);
        check("rst_level", bus.evt_level, 0);
        check("rst_data", bus.evt_data, 0);
        check("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        cyc();

        // Press, repeat frames 2..9, release.
        expect_evt(T_PRESS, 16'h10EF);
        ack_code(16'h10EF, 8'd1);
        check("a_state_held", bus.state, S_HELD);
        for (int c = 2; c <= 9; c++) begin
            if (rpt_on && (c == 6 || c == 8)) expect_evt(T_REPEAT, 16'h10EF);
            frame(8'(c));
        end
        expect_evt(T_REL, 16'h10EF);
        bus.ir_code     = 16'd0;
        bus.ir_code_cnt = 8'd0;
        cyc();
        check("a_state_drain", bus.state, S_DRAIN);
        cyc();
        check("a_state_idle", bus.state, S_IDLE);
        wait_drain("a_drain");
        check("a_level", bus.evt_level, 0);

        // Key switch: RELEASE then PRESS in consecutive pushes.
        expect_evt(T_PRESS, 16'h10EF);
        ack_code(16'h10EF, 8'd1);
        wait_drain("b_press_drain");
        bus.evt_ready = 1'b0;
        expect_evt(T_REL, 16'h10EF);
        expect_evt(T_PRESS, 16'h20DF);
        bus.ir_code     = 16'h20DF;
        bus.ir_code_ack = 1'b1;
        cyc();
        bus.ir_code_ack = 1'b0;
        check("b_state_switch", bus.state, S_SWITCH);
        check("b_level1", bus.evt_level, 1);
        cyc();
        check("b_state_held", bus.state, S_HELD);
        check("b_level2", bus.evt_level, 2);
        bus.evt_ready = 1'b1;
        wait_drain("b_drain");
        expect_evt(T_REL, 16'h20DF);
        release_key();
        wait_drain("b_rel_drain");

        // Overflow: fifth event dropped even with ovf_clr high in that cycle.
        bus.evt_ready = 1'b0;
        expect_evt(T_PRESS, 16'h0001);
        ack_code(16'h0001, 8'd1);
        expect_evt(T_REL, 16'h0001);
        expect_evt(T_PRESS, 16'h0002);
        ack_code(16'h0002, 8'd1);
        expect_evt(T_REL, 16'h0002);
        bus.ovf_clr = 1'b1;
        ack_code(16'h0003, 8'd1);
        bus.ovf_clr = 1'b0;
        check("c_level_full", bus.evt_level, 4);
        check("c_ovf_set", bus.ovf, 1);
        bus.ovf_clr = 1'b1;
        cyc();
        bus.ovf_clr = 1'b0;
        check("c_ovf_clr", bus.ovf, 0);
        bus.evt_ready = 1'b1;
        wait_drain("c_drain");
        check("c_level_empty", bus.evt_level, 0);
        expect_evt(T_REL, 16'h0003);
        release_key();
        wait_drain("c_rel_drain");

        // Full queue with push and pop on the same edge.
        bus.evt_ready = 1'b0;
        expect_evt(T_PRESS, 16'h0A0A);
        ack_code(16'h0A0A, 8'd1);
        expect_evt(T_REL, 16'h0A0A);
        expect_evt(T_PRESS, 16'h0B0B);
        ack_code(16'h0B0B, 8'd1);
        expect_evt(T_REL, 16'h0B0B);
        expect_evt(T_PRESS, 16'h0C0C);
        bus.ir_code     = 16'h0C0C;
        bus.ir_code_ack = 1'b1;
        cyc();
        bus.ir_code_ack = 1'b0;
        check("d_level_full", bus.evt_level, 4);
        bus.evt_ready = 1'b1;
        cyc();
        bus.evt_ready = 1'b0;
        check("d_level_keep", bus.evt_level, 4);
        check("d_ovf_clear", bus.ovf, 0);
        bus.evt_ready = 1'b1;
        wait_drain("d_drain");
        expect_evt(T_REL, 16'h0C0C);
        release_key();
        wait_drain("d_rel_drain");

        // Receiver counter wrap 255->0->1 while held.
        expect_evt(T_PRESS, 16'h10EF);
        ack_code(16'h10EF, 8'd1);
        for (int c = 2; c <= 8; c++) begin
            if (rpt_on && (c == 6 || c == 8)) expect_evt(T_REPEAT, 16'h10EF);
            frame(8'(c));
        end
        frame(8'd255);
        frame(8'd0);
        frame(8'd1);
        cyc();
        expect_evt(T_REL, 16'h10EF);
        release_key();
        wait_drain("e_drain");

        // en=0 while held with two queued events.
        expect_evt(T_PRESS, 16'h30CF);
        ack_code(16'h30CF, 8'd1);
        wait_drain("f_press_drain");
        bus.evt_ready = 1'b0;
        expect_evt(T_REL, 16'h30CF);
        expect_evt(T_PRESS, 16'h40BF);
        ack_code(16'h40BF, 8'd1);
        check("f_level2", bus.evt_level, 2);
        check("f_state_held", bus.state, S_HELD);
        bus.en      = 1'b0;
        bus.ir_code = 16'd0;
        cyc();
        check("f_state_idle", bus.state, S_IDLE);
        cyc();
        cyc();
        check("f_level_kept", bus.evt_level, 2);
        bus.en        = 1'b1;
        bus.evt_ready = 1'b1;
        wait_drain("f_drain");
        cyc();
        check("f_level_empty", bus.evt_level, 0);
        check("f_state_end", bus.state, S_IDLE);

        // Reset while held with a pending event: nothing survives, no RELEASE.
        bus.evt_ready = 1'b0;
        ack_code(16'h50AF, 8'd1);
        check("g_level_pending", bus.evt_level, 1);
        rst_n = 1'b0;
        #1;
        check("g_rst_level", bus.evt_level, 0);
        check("g_rst_valid", bus.evt_valid, 0);
        check("g_rst_state", bus.state, S_IDLE);
        check("g_rst_data", bus.evt_data, 0);
        bus.ir_code     = 16'd0;
        bus.ir_code_cnt = 8'd0;
        cyc();
        rst_n         = 1'b1;
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        check("g_level_after", bus.evt_level, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_key_sched.md
IR_KEY_SCHED -- requirements
Module: ir_key_sched

Interface
REQ-001 Parameter RPT_DELAY, default 4: repeat frames after PRESS before the first REPEAT event.
REQ-002 Parameter RPT_DIV, default 2, range 1-15: one REPEAT event emitted per RPT_DIV repeat frames after the delay.
REQ-003 Port clk27  in  1: system clock; all logic SHALL run on its rising edge.
REQ-004 Port reset_n  in  1: asynchronous active-low reset.
REQ-005 Port en  in  1: scheduler enable.
REQ-006 Port ir_code  in  16: current decoded code from the IR receiver; 0 means no key held.
REQ-007 Port ir_code_ack  in  1: one-cycle pulse meaning a valid full frame was decoded into ir_code.
REQ-008 Port ir_code_cnt  in  8: receiver repeat counter; it is set to 1 on a new frame, increments per repeat frame and clears to 0 on release.
REQ-009 Port evt_data  out  18: head event, {type[1:0], code[15:0]}; type 01=PRESS, 10=REPEAT, 11=RELEASE.
REQ-010 Port evt_valid  out  1: the FIFO is not empty.
REQ-011 Port evt_ready  in  1: consumer pop; a pop occurs when evt_valid and evt_ready are both 1.
REQ-012 Port evt_level  out  3: FIFO occupancy, 0-4.
REQ-013 Port ovf  out  1: sticky flag indicating an event was dropped.
REQ-014 Port ovf_clr  in  1: clears ovf.

Function
REQ-015 The FSM SHALL have four states: IDLE, HELD, SWITCH and DRAIN.
REQ-016 In IDLE, an ir_code_ack with ir_code!=0 SHALL push PRESS(ir_code), latch cur_code, clear rpt_seen and div_cnt, and go to HELD.
REQ-017 In HELD, an ir_code_ack with ir_code==cur_code SHALL push no event and SHALL clear rpt_seen and div_cnt.
REQ-018 In HELD, an ir_code_ack with ir_code!=cur_code and ir_code!=0 SHALL push RELEASE(cur_code), latch new_code and go to SWITCH.
REQ-019 In SWITCH, the block SHALL push PRESS(new_code), set cur_code=new_code, clear rpt_seen and div_cnt, and return to HELD one cycle later.
REQ-020 In HELD, a sampled ir_code==0 SHALL push RELEASE(cur_code) and go to DRAIN.
REQ-021 DRAIN SHALL last exactly one cycle and then go to IDLE; ir_code_ack SHALL be ignored during DRAIN.
REQ-022 A repeat frame SHALL be detected only in HELD, as ir_code_cnt differing from its registered previous value with new value >=2.
REQ-023 rpt_seen SHALL be 8 bits, increment on each repeat frame, and saturate at 255.
REQ-024 A repeat frame with rpt_seen (pre-increment) >= RPT_DELAY SHALL decrement div_cnt, and SHALL push REPEAT(cur_code) and reload div_cnt=RPT_DIV-1 when div_cnt==0.
REQ-025 Receiver counter wrap (255->0) SHALL NOT create a repeat frame, because of the >=2 rule in REQ-022.
REQ-026 If release and ack are sampled in the same cycle in HELD, release SHALL take priority.
REQ-027 en=0 SHALL force the FSM to IDLE within 1 cycle, generate no events and no RELEASE, and preserve FIFO contents.
REQ-028 The FIFO SHALL be 4 entries deep with first-in first-out order.
REQ-029 A push to an empty FIFO SHALL raise evt_valid on the next cycle.
REQ-030 When the FIFO is full, a push SHALL be accepted only if a pop occurs in the same cycle; otherwise the event is dropped and ovf is set.
REQ-031 Simultaneous push and pop SHALL leave evt_level unchanged.
REQ-032 A pop on an empty FIFO SHALL be ignored.
REQ-033 Setting ovf SHALL take priority over ovf_clr in the same cycle.
REQ-034 All FSM decisions SHALL use registered inputs sampled in the same cycle; the block SHALL NOT add any input synchronizer.

Reset
REQ-035 Assertion of reset_n SHALL immediately set state=IDLE, evt_valid=0, evt_level=0, evt_data=0, ovf=0, cur_code=0, rpt_seen=0 and div_cnt=0.
REQ-036 Reset during HELD SHALL emit no RELEASE.
REQ-037 Events pending at reset SHALL be discarded.

Configuration
REQ-038 The macro IR_KEY_REPEAT_EN SHALL control REPEAT generation.
REQ-039 When IR_KEY_REPEAT_EN is defined, REPEAT events SHALL be generated per REQ-022 to REQ-025.
REQ-040 When IR_KEY_REPEAT_EN is undefined, rpt_seen and div_cnt SHALL be absent, no REPEAT event SHALL ever be pushed, and PRESS/RELEASE behaviour SHALL be unchanged.

Verification
REQ-041 Scenario, with RPT_DELAY=4 and RPT_DIV=2 in all cases: ack with code 0x10EF, then ir_code_cnt 2..9, then ir_code=0 -> events PRESS 10EF, REPEAT x2 (at cnt 6 and 8), RELEASE 10EF.
REQ-042 Scenario: hold code 0x10EF, then ack with 0x20DF -> RELEASE 10EF and PRESS 20DF in consecutive pushes, evt_level=2 with evt_ready=0.
REQ-043 Scenario: hold evt_ready=0 and generate 5 events -> evt_level=4, ovf=1, first 4 events intact; pulse ovf_clr -> ovf=0.
REQ-044 Scenario: evt_level=4 with push and pop in the same cycle -> evt_level stays 4, ovf stays 0.
REQ-045 Scenario: ir_code_cnt wraps 255->0->1 while held -> no REPEAT event from the wrap.
REQ-046 Scenario: en=0 while in HELD with 2 queued events -> state=IDLE, no RELEASE, evt_level stays 2; rebuild with IR_KEY_REPEAT_EN undefined and rerun REQ-041 stimulus -> PRESS and RELEASE only.
